pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes decode tags from ID: rd_wren, mem_ren, is_ctrl, and rs-use flags derived from the opcode. Consumes EX redirect and memory handshakes.
- Produces per-stage stall/flush, operand forwarding selects and the PC-redirect select.
- Owns a small FSM for multi-cycle data-memory waits with a watchdog, plus saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before abort; legal range 2..255.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_id_rs1, i_id_rs2  in  5 each  source register indices in ID
- i_id_use_rs1, i_id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- i_ex_rd  in  5  destination register in EX
- i_ex_rd_wren, i_ex_mem_ren  in  1 each  EX writes rd; EX is a load
- i_ex_rs1, i_ex_rs2  in  5 each  source indices in EX, used for forwarding
- i_ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
- i_mem_rd, i_mem_rd_wren, i_mem_mem_ren  in  5/1/1  MEM-stage tags
- i_wb_rd, i_wb_rd_wren  in  5/1  WB-stage tags
- i_imem_vld  in  1  instruction fetch data valid this cycle
- i_dmem_req, i_dmem_ack  in  1 each  MEM stage access request; memory completion
- o_stall_if, o_stall_id, o_stall_ex, o_stall_mem  out  1 each  hold the stage register
- o_flush_id, o_flush_ex, o_flush_wb  out  1 each  load a bubble into the stage register
- o_pc_sel  out  1  0: PC+4, 1: EX target
- o_fwd_a_sel, o_fwd_b_sel  out  2 each  00 regfile, 01 MEM ALU result, 10 WB data
- o_mem_err  out  1  one-cycle pulse on watchdog abort
- o_stall_cnt, o_flush_cnt  out  CNT_W each  saturating performance counters

Behaviour:
- FSM states: RUN, MEM_WAIT, MEM_ABORT. Reset → RUN.
- RUN → MEM_WAIT when i_dmem_req & ~i_dmem_ack. The wait counter loads 1.
- MEM_WAIT → RUN on i_dmem_ack.
- MEM_WAIT → MEM_ABORT when the counter reaches MEM_TIMEOUT without an ack.
- MEM_ABORT → RUN unconditionally, after 1 cycle. o_mem_err = 1 only in MEM_ABORT.
- All stall/flush/forward outputs are combinational from state and inputs. Counters and state are registered.
- Priority per cycle, highest first:
  - (1) i_reset asserted: all stalls 0; o_flush_id, o_flush_ex, o_flush_wb all 1; o_pc_sel 0; fwd selects 00.
  - (2) Memory wait: RUN with i_dmem_req & ~i_dmem_ack, or MEM_WAIT without i_dmem_ack. Stall IF/ID/EX/MEM and flush WB. i_ex_redirect is ignored (EX is frozen, so the redirect is re-presented after release).
  - (3) MEM_ABORT: flush ID and EX, flush WB. No stalls. o_pc_sel 0. The aborted access is dropped.
  - (4) i_ex_redirect: o_pc_sel 1, flush ID and EX. Overrides load-use.
  - (5) Load-use: i_ex_mem_ren & i_ex_rd_wren & i_ex_rd≠0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)). Stall IF and ID, flush EX. Exactly 1 cycle per hazard.
  - (6) ~i_imem_vld: stall IF, flush ID.
  - (7) Otherwise no stall or flush.
- Ack in the same cycle as req: no wait, the FSM stays in RUN.
- Forwarding (operand A uses i_ex_rs1, B uses i_ex_rs2, rs==0 always 00):
  - 01 if i_mem_rd_wren & ~i_mem_mem_ren & mem_rd==rs.
  - Else 10 if i_wb_rd_wren & wb_rd==rs.
  - Else 00.
  - MEM beats WB when both match.
  - Forwarding selects are valid in all states except reset.
- o_stall_cnt: +1 in every cycle where o_stall_if=1.
- o_flush_cnt: +1 in every cycle where o_flush_ex=1 and the cause is a redirect or an abort.
- Both counters saturate at all-ones and reset to 0.
- Reset mid-MEM_WAIT: the FSM returns to RUN immediately (asynchronously) and the watchdog clears.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum;
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - PC_SEL_SEQ/PC_SEL_TGT.
- One sub-module: fwd_sel, pure combinational. It is instantiated twice, once for operand A and once for operand B.

Test Plan:
- LW x5 in EX, ID ADD x6,x5,x1: stall_if=stall_id=1 and flush_ex=1 for exactly 1 cycle, then clear; stall_cnt=1.
- Taken BEQ (i_ex_redirect=1) together with a load-use hazard: pc_sel=1, flush_id=flush_ex=1, stall_if=0; flush_cnt=1.
- i_dmem_req=1, ack after 3 cycles: stall_if/id/ex/mem=1 and flush_wb=1 for 3 cycles, then RUN; a redirect asserted during the wait has pc_sel=0 until release.
- MEM_TIMEOUT=4, i_dmem_req held, no ack: after 4 MEM_WAIT cycles, o_mem_err=1 for 1 cycle with flush_id/ex/wb=1, then RUN.
- MEM rd=x3 (ALU op), WB rd=x3, EX rs1=x3, rs2=x0: fwd_a=01, fwd_b=00; with MEM a load: fwd_a=10.
- Force o_stall_cnt to all-ones, then apply more stalls: it stays all-ones. Assert i_reset mid-MEM_WAIT: state RUN, counters 0, flush outputs 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the RV32I pipeline hazard/sequencing controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MEM_WAIT  = 2'd1,
      ST_MEM_ABORT = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_TGT = 1'b1;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic flush_wb;
      logic pc_sel;
   } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage tags, memory handshakes and control outputs exchanged with pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       i_id_rs1, i_id_rs2;
   logic             i_id_use_rs1, i_id_use_rs2;
   logic [4:0]       i_ex_rd;
   logic             i_ex_rd_wren, i_ex_mem_ren;
   logic [4:0]       i_ex_rs1, i_ex_rs2;
   logic             i_ex_redirect;
   logic [4:0]       i_mem_rd;
   logic             i_mem_rd_wren, i_mem_mem_ren;
   logic [4:0]       i_wb_rd;
   logic             i_wb_rd_wren;
   logic             i_imem_vld;
   logic             i_dmem_req, i_dmem_ack;
   logic             o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
   logic             o_flush_id, o_flush_ex, o_flush_wb;
   logic             o_pc_sel;
   logic [1:0]       o_fwd_a_sel, o_fwd_b_sel;
   logic             o_mem_err;
   logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

   modport master (
      output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
      output i_ex_rd, i_ex_rd_wren, i_ex_mem_ren, i_ex_rs1, i_ex_rs2, i_ex_redirect,
      output i_mem_rd, i_mem_rd_wren, i_mem_mem_ren, i_wb_rd, i_wb_rd_wren,
      output i_imem_vld, i_dmem_req, i_dmem_ack,
      input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
      input  o_flush_id, o_flush_ex, o_flush_wb, o_pc_sel,
      input  o_fwd_a_sel, o_fwd_b_sel, o_mem_err, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
      input  i_ex_rd, i_ex_rd_wren, i_ex_mem_ren, i_ex_rs1, i_ex_rs2, i_ex_redirect,
      input  i_mem_rd, i_mem_rd_wren, i_mem_mem_ren, i_wb_rd, i_wb_rd_wren,
      input  i_imem_vld, i_dmem_req, i_dmem_ack,
      output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
      output o_flush_id, o_flush_ex, o_flush_wb, o_pc_sel,
      output o_fwd_a_sel, o_fwd_b_sel, o_mem_err, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/fwd_sel.sv
// Operand bypass select for one EX source register; MEM ALU result beats WB data.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_rd_wren,
   input  logic       mem_mem_ren,
   input  logic [4:0] wb_rd,
   input  logic       wb_rd_wren,
   output logic [1:0] sel
);

   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = FWD_REG;
      if (rs != 5'd0) begin
         // A load in MEM has no data yet; its value is only bypassable from WB.
         if (mem_rd_wren && !mem_mem_ren && (mem_rd == rs)) begin
            sel = FWD_MEM;
         end else if (wb_rd_wren && (wb_rd == rs)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, bypass selects, PC redirect,
// data-memory wait FSM with watchdog, and saturating stall/flush counters.
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic           i_clk,
   input logic           i_reset,
   pipeline_ctrl_if.slave bus
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t           state, next_state;
   logic [7:0]       wait_cnt;
   logic             mem_wait;
   logic             load_use;
   logic             cnt_flush;
   ctrl_t            ctrl;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   assign mem_wait = ((state == ST_RUN) && bus.i_dmem_req && !bus.i_dmem_ack) ||
                     ((state == ST_MEM_WAIT) && !bus.i_dmem_ack);

   assign load_use = bus.i_ex_mem_ren && bus.i_ex_rd_wren && (bus.i_ex_rd != 5'd0) &&
                     ((bus.i_id_use_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                      (bus.i_id_use_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));

   always_ff @(posedge i_clk or posedge i_reset) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      if (i_reset) state <= ST_RUN;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_RUN: begin
            if (bus.i_dmem_req && !bus.i_dmem_ack) next_state = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (bus.i_dmem_ack)             next_state = ST_RUN;
            else if (wait_cnt >= TIMEOUT)   next_state = ST_MEM_ABORT;
         end
         ST_MEM_ABORT: next_state = ST_RUN;
         default:      next_state = ST_RUN;
      endcase
   end

   // Prioritised stall/flush decision; cnt_flush marks EX flushes caused by redirect or abort.
   always_comb begin
      ctrl        = '0;
      ctrl.pc_sel = PC_SEL_SEQ;
      cnt_flush   = 1'b0;
      if (i_reset) begin
         ctrl.flush_id = 1'b1;
         ctrl.flush_ex = 1'b1;
         ctrl.flush_wb = 1'b1;
      end else if (mem_wait) begin
         ctrl.stall_if  = 1'b1;
         ctrl.stall_id  = 1'b1;
         ctrl.stall_ex  = 1'b1;
         ctrl.stall_mem = 1'b1;
         ctrl.flush_wb  = 1'b1;
      end else if (state == ST_MEM_ABORT) begin
         ctrl.flush_id = 1'b1;
         ctrl.flush_ex = 1'b1;
         ctrl.flush_wb = 1'b1;
         cnt_flush     = 1'b1;
      end else if (bus.i_ex_redirect) begin
         ctrl.pc_sel   = PC_SEL_TGT;
         ctrl.flush_id = 1'b1;
         ctrl.flush_ex = 1'b1;
         cnt_flush     = 1'b1;
      end else if (load_use) begin
         ctrl.stall_if = 1'b1;
         ctrl.stall_id = 1'b1;
         ctrl.flush_ex = 1'b1;
      end else if (!bus.i_imem_vld) begin
         ctrl.stall_if = 1'b1;
         ctrl.flush_id = 1'b1;
      end
   end

   // Watchdog: 1 on the cycle the wait starts, counts MEM_WAIT cycles, idle at 0.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wait_cnt <= 8'd0;
      end else if ((state == ST_RUN) && bus.i_dmem_req && !bus.i_dmem_ack) begin
         wait_cnt <= 8'd1;
      end else if ((state == ST_MEM_WAIT) && !bus.i_dmem_ack) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ctrl.stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (cnt_flush && (flush_cnt != '1))     flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   fwd_sel u_fwd_a (
      .rs          (bus.i_ex_rs1),
      .mem_rd      (bus.i_mem_rd),
      .mem_rd_wren (bus.i_mem_rd_wren),
      .mem_mem_ren (bus.i_mem_mem_ren),
      .wb_rd       (bus.i_wb_rd),
      .wb_rd_wren  (bus.i_wb_rd_wren),
      .sel         (fwd_a)
   );

   fwd_sel u_fwd_b (
      .rs          (bus.i_ex_rs2),
      .mem_rd      (bus.i_mem_rd),
      .mem_rd_wren (bus.i_mem_rd_wren),
      .mem_mem_ren (bus.i_mem_mem_ren),
      .wb_rd       (bus.i_wb_rd),
      .wb_rd_wren  (bus.i_wb_rd_wren),
      .sel         (fwd_b)
   );

   assign bus.o_stall_if  = ctrl.stall_if;
   assign bus.o_stall_id  = ctrl.stall_id;
   assign bus.o_stall_ex  = ctrl.stall_ex;
   assign bus.o_stall_mem = ctrl.stall_mem;
   assign bus.o_flush_id  = ctrl.flush_id;
   assign bus.o_flush_ex  = ctrl.flush_ex;
   assign bus.o_flush_wb  = ctrl.flush_wb;
   assign bus.o_pc_sel    = ctrl.pc_sel;
   assign bus.o_fwd_a_sel = i_reset ? FWD_REG : fwd_a;
   assign bus.o_fwd_b_sel = i_reset ? FWD_REG : fwd_b;
   assign bus.o_mem_err   = (state == ST_MEM_ABORT);
   assign bus.o_stall_cnt = stall_cnt;
   assign bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for single-cycle decisions,
// hand sequences for memory wait, watchdog abort, counter saturation and reset.
module tb_pipeline_ctrl;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   exp_stall;
   int   exp_flush;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Fields are ints to keep the table literal-friendly; exp_ctrl bit order is
   // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, pc_sel}.
   typedef struct {
      int id_rs1, id_rs2, use1, use2;
      int ex_rd, ex_wren, ex_ren, ex_rs1, ex_rs2, redir;
      int mem_rd, mem_wren, mem_ren, wb_rd, wb_wren, imem_vld;
      int exp_ctrl, exp_a, exp_b;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_bits();
      return 32'({bus.o_stall_if, bus.o_stall_id, bus.o_stall_ex, bus.o_stall_mem,
                  bus.o_flush_id, bus.o_flush_ex, bus.o_flush_wb, bus.o_pc_sel});
   endfunction

   task automatic set_idle();
      bus.i_id_rs1 = 5'd0;      bus.i_id_rs2 = 5'd0;
      bus.i_id_use_rs1 = 1'b0;  bus.i_id_use_rs2 = 1'b0;
      bus.i_ex_rd = 5'd0;       bus.i_ex_rd_wren = 1'b0;  bus.i_ex_mem_ren = 1'b0;
      bus.i_ex_rs1 = 5'd0;      bus.i_ex_rs2 = 5'd0;      bus.i_ex_redirect = 1'b0;
      bus.i_mem_rd = 5'd0;      bus.i_mem_rd_wren = 1'b0; bus.i_mem_mem_ren = 1'b0;
      bus.i_wb_rd = 5'd0;       bus.i_wb_rd_wren = 1'b0;
      bus.i_imem_vld = 1'b1;    bus.i_dmem_req = 1'b0;    bus.i_dmem_ack = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      bus.i_id_rs1      = 5'(v.id_rs1);
      bus.i_id_rs2      = 5'(v.id_rs2);
      bus.i_id_use_rs1  = v.use1[0];
      bus.i_id_use_rs2  = v.use2[0];
      bus.i_ex_rd       = 5'(v.ex_rd);
      bus.i_ex_rd_wren  = v.ex_wren[0];
      bus.i_ex_mem_ren  = v.ex_ren[0];
      bus.i_ex_rs1      = 5'(v.ex_rs1);
      bus.i_ex_rs2      = 5'(v.ex_rs2);
      bus.i_ex_redirect = v.redir[0];
      bus.i_mem_rd      = 5'(v.mem_rd);
      bus.i_mem_rd_wren = v.mem_wren[0];
      bus.i_mem_mem_ren = v.mem_ren[0];
      bus.i_wb_rd       = 5'(v.wb_rd);
      bus.i_wb_rd_wren  = v.wb_wren[0];
      bus.i_imem_vld    = v.imem_vld[0];
      bus.i_dmem_req    = 1'b0;
      bus.i_dmem_ack    = 1'b0;
   endtask

   // Inputs change at posedge+1, outputs are sampled at the following negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            rs1 rs2 u1 u2 exrd wr ren exrs1 exrs2 redir mrd mwr mren wrd wwr ivld ctrl   a  b
      vecs[0]  = '{ 0,  0,  0, 0, 0,   0, 0,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'h00, 0, 0};
      vecs[1]  = '{ 5,  1,  1, 1, 5,   1, 1,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'hC4, 0, 0};
      vecs[2]  = '{ 1,  5,  1, 1, 5,   1, 1,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'hC4, 0, 0};
      vecs[3]  = '{ 5,  1,  0, 1, 5,   1, 1,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'h00, 0, 0};
      vecs[4]  = '{ 0,  0,  1, 1, 0,   1, 1,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'h00, 0, 0};
      vecs[5]  = '{ 5,  5,  1, 1, 5,   1, 0,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'h00, 0, 0};
      vecs[6]  = '{ 5,  5,  1, 1, 5,   0, 1,  0,    0,    0,    0,  0,  0,   0,  0,  1,   'h00, 0, 0};
      vecs[7]  = '{ 5,  1,  1, 1, 5,   1, 1,  0,    0,    1,    0,  0,  0,   0,  0,  1,   'h0D, 0, 0};
      vecs[8]  = '{ 0,  0,  0, 0, 0,   0, 0,  0,    0,    0,    0,  0,  0,   0,  0,  0,   'h88, 0, 0};
      vecs[9]  = '{ 5,  1,  1, 1, 5,   1, 1,  0,    0,    0,    0,  0,  0,   0,  0,  0,   'hC4, 0, 0};
      vecs[10] = '{ 0,  0,  0, 0, 0,   0, 0,  0,    0,    1,    0,  0,  0,   0,  0,  0,   'h0D, 0, 0};
      vecs[11] = '{ 0,  0,  0, 0, 0,   0, 0,  3,    0,    0,    3,  1,  0,   3,  1,  1,   'h00, 1, 0};
      vecs[12] = '{ 0,  0,  0, 0, 0,   0, 0,  3,    0,    0,    3,  1,  1,   3,  1,  1,   'h00, 2, 0};
      vecs[13] = '{ 0,  0,  0, 0, 0,   0, 0,  7,    3,    0,    3,  0,  0,   3,  1,  1,   'h00, 0, 2};
      vecs[14] = '{ 0,  0,  0, 0, 0,   0, 0,  0,    0,    0,    0,  1,  0,   0,  1,  1,   'h00, 0, 0};
      vecs[15] = '{ 0,  0,  0, 0, 0,   0, 0,  4,    4,    0,    4,  1,  0,   9,  1,  1,   'h00, 1, 1};
      vecs[16] = '{ 0,  0,  0, 0, 0,   0, 0,  4,    0,    0,    4,  0,  0,   4,  0,  1,   'h00, 0, 0};

      // Reset dominates a pending memory wait and live bypass matches.
      rst = 1'b1;
      set_idle();
      bus.i_dmem_req    = 1'b1;
      bus.i_ex_rs1      = 5'd3;
      bus.i_mem_rd      = 5'd3;
      bus.i_mem_rd_wren = 1'b1;
      bus.i_ex_rs2      = 5'd3;
      bus.i_wb_rd       = 5'd3;
      bus.i_wb_rd_wren  = 1'b1;
      @(negedge clk);
      check("reset_ctrl", ctrl_bits(), 32'h0E);
      check("reset_fwd_a", 32'(bus.o_fwd_a_sel), 32'h0);
      check("reset_fwd_b", 32'(bus.o_fwd_b_sel), 32'h0);
      check("reset_mem_err", 32'(bus.o_mem_err), 32'h0);
      check("reset_stall_cnt", 32'(bus.o_stall_cnt), 32'h0);
      check("reset_flush_cnt", 32'(bus.o_flush_cnt), 32'h0);
      next_cycle();
      set_idle();
      rst = 1'b0;

      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 17; i++) begin
         apply(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d_ctrl", i), ctrl_bits(), 32'(vecs[i].exp_ctrl));
         check($sformatf("vec%0d_fwd_a", i), 32'(bus.o_fwd_a_sel), 32'(vecs[i].exp_a));
         check($sformatf("vec%0d_fwd_b", i), 32'(bus.o_fwd_b_sel), 32'(vecs[i].exp_b));
         if (vecs[i].exp_ctrl[7]) exp_stall++;
         if (vecs[i].exp_ctrl[0]) exp_flush++;
         next_cycle();
      end
      set_idle();
      @(negedge clk);
      check("table_stall_cnt", 32'(bus.o_stall_cnt), 32'(exp_stall));
      check("table_flush_cnt", 32'(bus.o_flush_cnt), 32'(exp_flush));
      next_cycle();

      // Ack after 3 cycles with a redirect pending: redirect waits for release.
      bus.i_dmem_req    = 1'b1;
      bus.i_ex_redirect = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("wait%0d_ctrl", c), ctrl_bits(), 32'hF2);
         next_cycle();
      end
      bus.i_dmem_ack = 1'b1;
      @(negedge clk);
      check("wait_release_ctrl", ctrl_bits(), 32'h0D);
      next_cycle();
      set_idle();
      @(negedge clk);
      check("wait_after_ctrl", ctrl_bits(), 32'h00);
      check("wait_after_mem_err", 32'(bus.o_mem_err), 32'h0);
      next_cycle();

      // Same-cycle ack never enters MEM_WAIT.
      bus.i_dmem_req = 1'b1;
      bus.i_dmem_ack = 1'b1;
      @(negedge clk);
      check("fast_ack_ctrl", ctrl_bits(), 32'h00);
      next_cycle();
      set_idle();
      @(negedge clk);
      check("fast_ack_next_ctrl", ctrl_bits(), 32'h00);
      next_cycle();

      // Watchdog: one RUN cycle plus MEM_TIMEOUT MEM_WAIT cycles, then abort.
      bus.i_dmem_req = 1'b1;
      for (int c = 0; c < MEM_TIMEOUT + 1; c++) begin
         @(negedge clk);
         check($sformatf("to%0d_ctrl", c), ctrl_bits(), 32'hF2);
         check($sformatf("to%0d_mem_err", c), 32'(bus.o_mem_err), 32'h0);
         next_cycle();
      end
      bus.i_dmem_req = 1'b0;
      @(negedge clk);
      check("abort_ctrl", ctrl_bits(), 32'h0E);
      check("abort_mem_err", 32'(bus.o_mem_err), 32'h1);
      next_cycle();
      @(negedge clk);
      check("post_abort_ctrl", ctrl_bits(), 32'h00);
      check("post_abort_mem_err", 32'(bus.o_mem_err), 32'h0);
      check("post_abort_stall_cnt", 32'(bus.o_stall_cnt), 32'(exp_stall + 3 + MEM_TIMEOUT + 1));
      check("post_abort_flush_cnt", 32'(bus.o_flush_cnt), 32'(exp_flush + 2));
      next_cycle();

      // Drive stall_cnt past all-ones with fetch misses; it must hold.
      bus.i_imem_vld = 1'b0;
      for (int c = 0; c < 8; c++) next_cycle();
      bus.i_imem_vld = 1'b1;
      @(negedge clk);
      check("sat_stall_cnt", 32'(bus.o_stall_cnt), 32'hF);
      next_cycle();
      bus.i_imem_vld = 1'b0;
      next_cycle();
      next_cycle();
      bus.i_imem_vld = 1'b1;
      @(negedge clk);
      check("sat_hold_stall_cnt", 32'(bus.o_stall_cnt), 32'hF);
      next_cycle();

      // Asynchronous reset in the middle of a memory wait.
      bus.i_dmem_req = 1'b1;
      next_cycle();
      @(negedge clk);
      check("pre_rst_wait_ctrl", ctrl_bits(), 32'hF2);
      next_cycle();
      #2 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ctrl", ctrl_bits(), 32'h0E);
      check("mid_rst_stall_cnt", 32'(bus.o_stall_cnt), 32'h0);
      check("mid_rst_flush_cnt", 32'(bus.o_flush_cnt), 32'h0);
      check("mid_rst_mem_err", 32'(bus.o_mem_err), 32'h0);
      #1;
      rst = 1'b0;
      bus.i_dmem_req = 1'b0;
      next_cycle();
      @(negedge clk);
      check("post_rst_ctrl", ctrl_bits(), 32'h00);
      check("post_rst_stall_cnt", 32'(bus.o_stall_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
